// File: rtl/nfc_phy_data_out_packer_if.sv
// nfc_phy_data_out_packer_if: 16-bit write-data stream into the DQ packer.
// Ports: iBuff_Valid/oBuff_Ready handshake, iBuff_Data, iBuff_Keep, iBuff_Last.
interface nfc_phy_data_out_packer_if;
    logic        iBuff_Valid;
    logic        oBuff_Ready;
    logic [15:0] iBuff_Data;
    logic [1:0]  iBuff_Keep;
    logic        iBuff_Last;

    modport master (
        output iBuff_Valid,
        output iBuff_Data,
        output iBuff_Keep,
        output iBuff_Last,
        input  oBuff_Ready
    );

    modport slave (
        input  iBuff_Valid,
        input  iBuff_Data,
        input  iBuff_Keep,
        input  iBuff_Last,
        output oBuff_Ready
    );
endinterface

// File: rtl/nfc_phy_data_out_packer.sv
// nfc_phy_data_out_packer: turns a 16-bit write stream into one NV-DDR
// data-input burst on the PHY DQ/DQS lanes, with pre/postamble and pauses.
// Ports: iSystemClock, iModuleReset_n, iStart, iNumOfData, buff (slave),
//        oDQSOutEnable, oDQOutEnable, oDQStrobe, oDQ, oBusy, oDone, oError.
module nfc_phy_data_out_packer #(
    parameter int unsigned PreambleCycles  = 1,
    parameter int unsigned PostambleCycles = 1,
    parameter logic [7:0]  PadByte         = 8'hFF
) (
    input  logic        iSystemClock,
    input  logic        iModuleReset_n,
    input  logic        iStart,
    input  logic [15:0] iNumOfData,
    nfc_phy_data_out_packer_if.slave buff,
    output logic        oDQSOutEnable,
    output logic        oDQOutEnable,
    output logic [7:0]  oDQStrobe,
    output logic [31:0] oDQ,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        POST,
        DONE
    } state_t;

    localparam logic [3:0] PreLoad  = 4'(PreambleCycles - 1);
    localparam logic [3:0] PostLoad = 4'(PostambleCycles - 1);

    state_t      rState;
    state_t      nState;
    logic [3:0]  rCnt;
    logic [3:0]  nCnt;
    logic [15:0] rRemain;
    logic [15:0] nRemain;
    logic        rReady;
    logic        nReady;
    logic        rDrain;
    logic        nDrain;
    logic [31:0] nDQ;
    logic [7:0]  nStrobe;
    logic        nError;
    logic        nBusy;
    logic        nEnable;
    logic        nDone;

    logic        accept;
    logic        fullWord;
    logic [7:0]  hiByte;
    logic [15:0] remainStep;
    logic        endBeat;

    assign buff.oBuff_Ready = rReady;

    always_comb begin
        nState  = rState;
        nCnt    = rCnt;
        nRemain = rRemain;
        nReady  = rReady;
        nDrain  = rDrain;
        nDQ     = oDQ;
        nStrobe = 8'h00;
        nError  = oError;

        accept   = rReady & buff.iBuff_Valid;
        fullWord = (buff.iBuff_Keep == 2'b11);
        hiByte   = fullWord ? buff.iBuff_Data[15:8] : PadByte;

        if (fullWord) begin
            remainStep = (rRemain > 16'd2) ? rRemain - 16'd2 : 16'd0;
        end else begin
            remainStep = (rRemain != 16'd0) ? rRemain - 16'd1 : 16'd0;
        end
        endBeat = buff.iBuff_Last | (remainStep == 16'd0);

        unique case (rState)
            IDLE: begin
                if (iStart) begin
                    nError  = 1'b0;
                    nRemain = iNumOfData;
                    nDQ     = 32'h0;
                    if (iNumOfData != 16'd0) begin
                        nState = PRE;
                        nCnt   = PreLoad;
                    end else begin
                        nState = DONE;
                    end
                end
            end
            PRE: begin
                if (rCnt == 4'd0) begin
                    nState = DATA;
                    nReady = (rRemain != 16'd0);
                end else begin
                    nCnt = rCnt - 4'd1;
                end
            end
            DATA: begin
                // rDrain: last word is on the lanes this cycle, so the
                // postamble starts on the next one.
                if (rDrain) begin
                    nState = POST;
                    nCnt   = PostLoad;
                    nDrain = 1'b0;
                end else if (accept) begin
                    nDQ     = {hiByte, hiByte,
                               buff.iBuff_Data[7:0],
                               buff.iBuff_Data[7:0]};
                    nStrobe = 8'b0011_0011;
                    nRemain = remainStep;
                    if (buff.iBuff_Last && remainStep != 16'd0) begin
                        nError = 1'b1;
                    end
                    if (!buff.iBuff_Last && remainStep == 16'd0) begin
                        nError = 1'b1;
                    end
                    if (!fullWord && !buff.iBuff_Last) begin
                        nError = 1'b1;
                    end
                    if (endBeat) begin
                        nReady = 1'b0;
                        nDrain = 1'b1;
                    end
                end
            end
            POST: begin
                if (rCnt == 4'd0) begin
                    nState = DONE;
                end else begin
                    nCnt = rCnt - 4'd1;
                end
            end
            DONE: begin
                nState = IDLE;
            end
            default: begin
                nState = IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line
        // up with the state the burst is actually in.
        nBusy   = (nState != IDLE);
        nEnable = (nState == PRE) | (nState == DATA) | (nState == POST);
        nDone   = (nState == DONE);
    end

    always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
        if (!iModuleReset_n) begin
            rState        <= IDLE;
            rCnt          <= 4'd0;
            rRemain       <= 16'd0;
            rReady        <= 1'b0;
            rDrain        <= 1'b0;
            oDQ           <= 32'h0;
            oDQStrobe     <= 8'h00;
            oDQSOutEnable <= 1'b0;
            oDQOutEnable  <= 1'b0;
            oBusy         <= 1'b0;
            oDone         <= 1'b0;
            oError        <= 1'b0;
        end else begin
            rState        <= nState;
            rCnt          <= nCnt;
            rRemain       <= nRemain;
            rReady        <= nReady;
            rDrain        <= nDrain;
            oDQ           <= nDQ;
            oDQStrobe     <= nStrobe;
            oDQSOutEnable <= nEnable;
            oDQOutEnable  <= nEnable;
            oBusy         <= nBusy;
            oDone         <= nDone;
            oError        <= nError;
        end
    end

endmodule

// File: tb/tb_nfc_phy_data_out_packer.sv
// tb_nfc_phy_data_out_packer: scoreboard bench for the DQ/DQS write packer.
// Drives bursts through the stream interface and checks lanes and status.
module tb_nfc_phy_data_out_packer;

    localparam int PRE  = 1;
    localparam int POST = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num = 16'd0;
    logic        dqsEn;
    logic        dqEn;
    logic [7:0]  strobe;
    logic [31:0] dq;
    logic        busy;
    logic        done;
    logic        err;

    nfc_phy_data_out_packer_if bus ();

    nfc_phy_data_out_packer #(
        .PreambleCycles  (PRE),
        .PostambleCycles (POST),
        .PadByte         (8'hFF)
    ) dut (
        .iSystemClock   (clk),
        .iModuleReset_n (rst_n),
        .iStart         (start),
        .iNumOfData     (num),
        .buff           (bus.slave),
        .oDQSOutEnable  (dqsEn),
        .oDQOutEnable   (dqEn),
        .oDQStrobe      (strobe),
        .oDQ            (dq),
        .oBusy          (busy),
        .oDone          (done),
        .oError         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
        int          gap;
    } beat_t;

    beat_t       beats[$];
    logic [31:0] expQ[$];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] laneWord(input beat_t b);
        logic [7:0] hi;
        hi = (b.keep == 2'b11) ? b.data[15:8] : 8'hFF;
        return {hi, hi, b.data[7:0], b.data[7:0]};
    endfunction

    task automatic addBeat(input logic [15:0] d, input logic [1:0] k,
                           input logic l, input int g);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        b.gap  = g;
        beats.push_back(b);
    endtask

    task automatic drive();
        bit ok;
        bus.iBuff_Valid = 1'b0;
        foreach (beats[i]) begin
            if (i > 0) begin
                repeat (beats[i].gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.iBuff_Data  = beats[i].data;
            bus.iBuff_Keep  = beats[i].keep;
            bus.iBuff_Last  = beats[i].last;
            bus.iBuff_Valid = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (bus.oBuff_Ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                chk("ready_timeout", 32'(ok), 32'd1);
                bus.iBuff_Valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            expQ.push_back(laneWord(beats[i]));
            bus.iBuff_Valid = 1'b0;
            bus.iBuff_Last  = 1'b0;
        end
    endtask

    task automatic runBurst(input logic [15:0] n, input logic expErr);
        int          w;
        int          gaps;
        int          en;
        int          zero;
        int          doneCyc;
        int          expLat;
        logic [31:0] lastDq;
        logic        fin;
        logic        doneEn;
        logic        doneBusy;
        logic        doneErr;

        w = beats.size();
        gaps = 0;
        foreach (beats[i]) begin
            if (i > 0) gaps += beats[i].gap;
        end
        expQ.delete();
        en = 0;
        zero = 0;
        doneCyc = 0;
        lastDq = 32'h0;
        fin = 1'b0;
        doneEn = 1'b1;
        doneBusy = 1'b0;
        doneErr = 1'b0;

        @(posedge clk);
        #1;
        num = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        fork
            drive();
            begin
                logic [31:0] e;
                for (int cyc = 1; cyc <= 300; cyc++) begin
                    @(negedge clk);
                    if (cyc == 1) chk("err_clear", 32'(err), 32'd0);
                    if (done) begin
                        fin = 1'b1;
                        doneCyc = cyc;
                        doneEn = dqsEn;
                        doneBusy = busy;
                        doneErr = err;
                        break;
                    end
                    chk("en_on", 32'(dqsEn), 32'd1);
                    chk("dq_en", 32'(dqEn), 32'(dqsEn));
                    if (dqsEn) begin
                        en++;
                        if (strobe == 8'h33) begin
                            if (expQ.size() == 0) begin
                                chk("extra_beat", 32'(expQ.size()), 32'd1);
                            end else begin
                                e = expQ.pop_front();
                                chk("dq", dq, e);
                                lastDq = e;
                            end
                        end else begin
                            chk("strobe_idle", 32'(strobe), 32'h0);
                            chk("dq_hold", dq, lastDq);
                            zero++;
                        end
                    end
                end
            end
        join

        expLat = (n == 16'd0) ? 1 : PRE + 1 + w + gaps + POST + 1;
        chk("done_seen", 32'(fin), 32'd1);
        chk("latency", 32'(doneCyc), 32'(expLat));
        chk("en_cycles", 32'(en),
            (n == 16'd0) ? 32'd0 : 32'(PRE + 1 + gaps + POST + w));
        chk("pause_cycles", 32'(zero),
            (n == 16'd0) ? 32'd0 : 32'(PRE + 1 + gaps + POST));
        chk("leftover", 32'(expQ.size()), 32'd0);
        chk("done_en", 32'(doneEn), 32'd0);
        chk("done_busy", 32'(doneBusy), 32'd1);
        chk("error", 32'(doneErr), 32'(expErr));
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_err", 32'(err), 32'(expErr));
        beats.delete();
    endtask

    initial begin
        int          n;
        int          w;
        logic        lst;
        logic [1:0]  k;
        bit          ok;

        bus.iBuff_Valid = 1'b0;
        bus.iBuff_Data  = 16'h0;
        bus.iBuff_Keep  = 2'b11;
        bus.iBuff_Last  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_dq", dq, 32'h0);
        chk("rst_strobe", 32'(strobe), 32'h0);
        chk("rst_dqs_en", 32'(dqsEn), 32'd0);
        chk("rst_dq_en", 32'(dqEn), 32'd0);
        chk("rst_ready", 32'(bus.oBuff_Ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        addBeat(16'hA1B0, 2'b11, 1'b0, 0);
        addBeat(16'hC3D2, 2'b11, 1'b1, 0);
        runBurst(16'd4, 1'b0);

        addBeat(16'h1234, 2'b11, 1'b0, 0);
        addBeat(16'h7755, 2'b01, 1'b1, 0);
        runBurst(16'd3, 1'b0);

        addBeat(16'h0102, 2'b11, 1'b0, 0);
        addBeat(16'h0304, 2'b11, 1'b0, 3);
        addBeat(16'h0506, 2'b11, 1'b1, 0);
        runBurst(16'd6, 1'b0);

        addBeat(16'hDEAD, 2'b11, 1'b0, 0);
        addBeat(16'hBEEF, 2'b11, 1'b1, 0);
        runBurst(16'd6, 1'b1);

        addBeat(16'h5A5A, 2'b11, 1'b1, 0);
        runBurst(16'd2, 1'b0);

        addBeat(16'h1111, 2'b11, 1'b0, 0);
        addBeat(16'h2222, 2'b11, 1'b0, 1);
        runBurst(16'd4, 1'b1);

        addBeat(16'h00AA, 2'b01, 1'b0, 0);
        addBeat(16'hBBCC, 2'b11, 1'b1, 0);
        runBurst(16'd3, 1'b1);

        runBurst(16'd0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 12));
            w = (n + 1) / 2;
            for (int i = 0; i < w; i++) begin
                lst = (i == w - 1);
                k = (lst && (n % 2 == 1)) ? 2'b01 : 2'b11;
                addBeat(16'($urandom), k, lst, int'($urandom_range(0, 2)));
            end
            runBurst(16'(n), 1'b0);
        end

        @(posedge clk);
        #1;
        num = 16'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bus.iBuff_Data  = 16'h9876;
        bus.iBuff_Keep  = 2'b11;
        bus.iBuff_Valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.oBuff_Ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_test_ready", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        chk("pre_rst_en", 32'(dqsEn), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dq", dq, 32'h0);
        chk("mid_rst_strobe", 32'(strobe), 32'h0);
        chk("mid_rst_dqs_en", 32'(dqsEn), 32'd0);
        chk("mid_rst_dq_en", 32'(dqEn), 32'd0);
        chk("mid_rst_ready", 32'(bus.oBuff_Ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        bus.iBuff_Valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        addBeat(16'hF00D, 2'b11, 1'b1, 0);
        runBurst(16'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
